// File: rtl/ppt_reg_arbiter.sv
// Configuration register bank shared by the I2C host port (SCL domain) and the local core.
// Host writes are synchronised and buffered; a two-state FSM round-robins the single access port.
module ppt_reg_arbiter #(
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             h_wr,
    input  logic [7:0]                       h_addr,
    input  logic [DATA_W-1:0]                h_wdata,
    output logic [DATA_W-1:0]                h_rdata,
    input  logic                             c_req,
    input  logic                             c_we,
    input  logic [ADDR_W-1:0]                c_addr,
    input  logic [DATA_W-1:0]                c_wdata,
    output logic                             c_gnt,
    output logic                             c_rvalid,
    output logic [DATA_W-1:0]                c_rdata,
    output logic [DATA_W*(2**ADDR_W)-1:0]    cfg_flat,
    output logic                             busy,
    output logic                             host_ovr,
    output logic                             host_drop
);
    localparam int unsigned Depth = 2 ** ADDR_W;

    typedef enum logic {StIdle, StAccess} state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   h_rise, h_in_range, h_capture;

    logic                   pend_q, pend_d;
    logic [ADDR_W-1:0]      pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0]      pend_wdata_q, pend_wdata_d;
    logic                   ovr_q, ovr_d;
    logic                   drop_q, drop_d;

    state_e                 state_q, state_d;
    logic                   win_host_q, win_host_d;
    logic                   last_host_q, last_host_d;
    logic                   host_acc, core_acc;

    logic [DATA_W-1:0]      bank_q [Depth];
    logic                   we;
    logic [ADDR_W-1:0]      waddr;
    logic [DATA_W-1:0]      wdata;
    logic [DATA_W-1:0]      h_rdata_q, c_rdata_q;
    logic                   c_rvalid_q;

    assign h_rise     = sync_q[SYNC_STAGES-1] & ~edge_q;
    assign h_in_range = (h_addr >> ADDR_W) == '0;
    assign h_capture  = h_rise & h_in_range;

    assign host_acc = (state_q == StAccess) &  win_host_q;
    assign core_acc = (state_q == StAccess) & ~win_host_q;

    always_comb begin
        pend_d       = pend_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;
        ovr_d        = ovr_q;
        drop_d       = drop_q;
        if (h_rise && !h_in_range) begin
            drop_d = 1'b1;
        end
        // A fresh capture beats the commit of the old entry in the same cycle.
        if (h_capture) begin
            if (pend_q && !host_acc) begin
                ovr_d = 1'b1;
            end
            pend_d       = 1'b1;
            pend_addr_d  = h_addr[ADDR_W-1:0];
            pend_wdata_d = h_wdata;
        end else if (host_acc) begin
            pend_d = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        win_host_d  = win_host_q;
        last_host_d = last_host_q;
        unique case (state_q)
            StIdle: begin
                if (pend_q || c_req) begin
                    state_d     = StAccess;
                    win_host_d  = pend_q && (!c_req || !last_host_q);
                    last_host_d = win_host_d;
                end
            end
            StAccess: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        we    = host_acc | (core_acc & c_we);
        waddr = host_acc ? pend_addr_q : c_addr;
        wdata = host_acc ? pend_wdata_q : c_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            edge_q       <= 1'b0;
            pend_q       <= 1'b0;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
            ovr_q        <= 1'b0;
            drop_q       <= 1'b0;
            state_q      <= StIdle;
            win_host_q   <= 1'b0;
            last_host_q  <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], h_wr};
            edge_q       <= sync_q[SYNC_STAGES-1];
            pend_q       <= pend_d;
            pend_addr_q  <= pend_addr_d;
            pend_wdata_q <= pend_wdata_d;
            ovr_q        <= ovr_d;
            drop_q       <= drop_d;
            state_q      <= state_d;
            win_host_q   <= win_host_d;
            last_host_q  <= last_host_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                bank_q[i] <= '0;
            end
        end else if (we) begin
            bank_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_rdata_q  <= '0;
            c_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
        end else begin
            h_rdata_q  <= h_in_range ? bank_q[h_addr[ADDR_W-1:0]] : '0;
            c_rvalid_q <= core_acc & ~c_we;
            if (core_acc && !c_we) begin
                c_rdata_q <= bank_q[c_addr];
            end
        end
    end

    for (genvar gi = 0; gi < Depth; gi++) begin : g_cfg
        assign cfg_flat[gi*DATA_W +: DATA_W] = bank_q[gi];
    end

    assign h_rdata   = h_rdata_q;
    assign c_gnt     = core_acc;
    assign c_rvalid  = c_rvalid_q;
    assign c_rdata   = c_rdata_q;
    assign busy      = (state_q == StAccess) | pend_q;
    assign host_ovr  = ovr_q;
    assign host_drop = drop_q;

endmodule

// File: tb/tb_ppt_reg_arbiter.sv
// Bench for ppt_reg_arbiter: directed scenarios plus random host/core traffic, checked every
// cycle against a transaction-level model of the bank, the pending buffer and the arbiter.
module tb_ppt_reg_arbiter;
    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int S     = 2;
    localparam int DEPTH = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           h_wr = 1'b0;
    logic [7:0]     h_addr = '0;
    logic [DW-1:0]  h_wdata = '0;
    logic [DW-1:0]  h_rdata;
    logic           c_req = 1'b0;
    logic           c_we = 1'b0;
    logic [AW-1:0]  c_addr = '0;
    logic [DW-1:0]  c_wdata = '0;
    logic           c_gnt, c_rvalid;
    logic [DW-1:0]  c_rdata;
    logic [DW*DEPTH-1:0] cfg_flat;
    logic           busy, host_ovr, host_drop;

    always #5 clk = ~clk;

    ppt_reg_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .h_wr(h_wr), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_rdata(h_rdata), .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .cfg_flat(cfg_flat),
        .busy(busy), .host_ovr(host_ovr), .host_drop(host_drop)
    );

    // Model: bank contents, one-entry host buffer, an access slot owned by host or core.
    logic [DW-1:0] m_bank [DEPTH];
    bit            m_hist [$];          // h_wr as seen at recent edges, oldest first
    bit            m_pend;
    int            m_pa;
    logic [DW-1:0] m_pd;
    bit            m_access, m_acc_host, m_last_host;
    logic [DW-1:0] e_hrdata, e_rdata;
    bit            e_rvalid, e_ovr, e_drop;
    bit            chk_en = 1'b0;
    int            vectors = 0;
    int            miscompares = 0;

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) m_bank[i] = '0;
        m_hist = {};
        for (int i = 0; i <= S; i++) m_hist.push_back(1'b0);
        m_pend = 0; m_pa = 0; m_pd = '0;
        m_access = 0; m_acc_host = 0; m_last_host = 0;
        e_hrdata = '0; e_rdata = '0; e_rvalid = 0; e_ovr = 0; e_drop = 0;
    endfunction

    function automatic void model_edge();
        logic [DW-1:0] old [DEPTH];
        bit rise, inr, hsvc, csvc, win;
        int ha;
        old  = m_bank;
        ha   = int'(h_addr);
        inr  = ha < DEPTH;
        rise = m_hist[1] && !m_hist[0];
        hsvc = m_access && m_acc_host;
        csvc = m_access && !m_acc_host;
        if (hsvc) m_bank[m_pa] = m_pd;
        if (csvc && c_we) m_bank[int'(c_addr)] = c_wdata;
        e_rvalid = csvc && !c_we;
        if (e_rvalid) e_rdata = old[int'(c_addr)];
        e_hrdata = inr ? old[ha] : '0;
        if (rise && !inr) e_drop = 1;
        if (m_access) begin
            m_access = 0;
        end else if (m_pend || c_req) begin
            win = m_pend && (!c_req || !m_last_host);
            m_access = 1; m_acc_host = win; m_last_host = win;
        end
        if (rise && inr) begin
            if (m_pend && !hsvc) e_ovr = 1;
            m_pend = 1; m_pa = ha; m_pd = h_wdata;
        end else if (hsvc) begin
            m_pend = 0;
        end
        void'(m_hist.pop_front());
        m_hist.push_back(h_wr);
    endfunction

    function automatic bit exp_gnt();
        return m_access && !m_acc_host;
    endfunction

    function automatic logic [63:0] m_flat();
        logic [63:0] f = '0;
        for (int i = 0; i < DEPTH; i++) f[i*DW +: DW] = m_bank[i];
        return f;
    endfunction

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        else model_reset();
        #1;
    endtask

    // Per-cycle comparison against the model, plus grant-latency and request-hold checks.
    int wait_cnt = 0;
    bit req_prev = 1'b0, gnt_prev = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("h_rdata", 64'(h_rdata), 64'(e_hrdata));
            check("c_gnt", 64'(c_gnt), 64'(exp_gnt()));
            check("c_rvalid", 64'(c_rvalid), 64'(e_rvalid));
            check("c_rdata", 64'(c_rdata), 64'(e_rdata));
            check("cfg_flat", cfg_flat, m_flat());
            check("busy", 64'(busy), 64'(m_access || m_pend));
            check("host_ovr", 64'(host_ovr), 64'(e_ovr));
            check("host_drop", 64'(host_drop), 64'(e_drop));
            if (rst_n && c_req && !c_gnt) begin
                wait_cnt++;
                if (wait_cnt > 3) begin
                    miscompares++;
                    $display("FAIL gnt_latency: %0d cycles without c_gnt, limit 3", wait_cnt);
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
            if (rst_n && req_prev && !c_req && !gnt_prev) begin
                miscompares++;
                $display("FAIL req_drop: c_req fell with c_gnt=0 in prior cycle, need c_gnt=1");
            end
        end
        req_prev = c_req;
        gnt_prev = c_gnt;
    end

    int h_cnt = 0;

    initial begin
        bit g_prev;
        model_reset();
        chk_en = 1'b1;
        step(); step();
        rst_n = 1'b1;
        check("rst_cfg", cfg_flat, 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_flags", 64'({host_ovr, host_drop, c_rvalid, c_gnt}), 64'h0);

        // Host write 0x02 <= 0xA5
        h_addr = 8'h02; h_wdata = 8'hA5; h_wr = 1'b1;
        step(); step();
        check("hw_busy_E", 64'(busy), 64'h0);
        step();
        check("hw_busy_pend", 64'(busy), 64'h1);
        step(); step();
        check("hw_cfg2", 64'(cfg_flat[23:16]), 64'hA5);
        step();
        check("hw_hrdata", 64'(h_rdata), 64'hA5);
        check("hw_ovr", 64'(host_ovr), 64'h0);
        h_wr = 1'b0;

        // Core read of address 2
        c_req = 1'b1; c_we = 1'b0; c_addr = 3'd2;
        step();
        check("cr_gnt", 64'(c_gnt), 64'h1);
        step();
        check("cr_rvalid", 64'(c_rvalid), 64'h1);
        check("cr_rdata", 64'(c_rdata), 64'hA5);
        c_req = 1'b0;
        step();
        check("cr_rvalid_pulse", 64'(c_rvalid), 64'h0);

        // Host pending and core request arrive together; host wins each tie after a core grant
        for (int i = 0; i < 4; i++) begin
            repeat (3) step();
            h_addr = (i < 2) ? 8'(i) : 8'(i + 4); h_wdata = 8'(8'h10 + i); h_wr = 1'b1;
            step(); step(); step();
            c_req = 1'b1; c_we = 1'b0; c_addr = 3'(i);
            check("tie_busy", 64'(busy), 64'h1);
            step();
            check("tie_host_first", 64'({busy, c_gnt}), 64'h2);
            step();
            check("tie_idle_gap", 64'(c_gnt), 64'h0);
            step();
            check("tie_core_second", 64'(c_gnt), 64'h1);
            step();
            c_req = 1'b0; h_wr = 1'b0;
        end

        // Out-of-range host write is dropped
        repeat (3) step();
        h_addr = 8'h09; h_wdata = 8'h33; h_wr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("drop_busy", 64'(busy), 64'h0);
            if (i == 3) check("drop_flag", 64'(host_drop), 64'h1);
        end
        check("drop_hrdata", 64'(h_rdata), 64'h0);
        h_wr = 1'b0;

        // Two host edges while the core keeps requesting: the second overwrites the first
        repeat (3) step();
        c_req = 1'b1; c_we = 1'b0; c_addr = 3'd0;
        h_addr = 8'h03; h_wdata = 8'h11; h_wr = 1'b1;
        step(); h_wr = 1'b0;
        step(); h_wr = 1'b1;
        step(); h_wr = 1'b0; h_addr = 8'h04; h_wdata = 8'h22;
        step();
        check("ovr_not_yet", 64'(host_ovr), 64'h0);
        step();
        check("ovr_set", 64'(host_ovr), 64'h1);
        check("ovr_host_acc", 64'(c_gnt), 64'h0);
        step();
        check("ovr_slot4", 64'(cfg_flat[39:32]), 64'h22);
        check("ovr_slot3", 64'(cfg_flat[31:24]), 64'h00);
        step();
        check("ovr_core_gnt", 64'(c_gnt), 64'h1);
        step();
        c_req = 1'b0;

        // Reset in the middle of a core write ACCESS
        repeat (2) step();
        c_req = 1'b1; c_we = 1'b1; c_addr = 3'd5; c_wdata = 8'h7E;
        step();
        check("rw_gnt", 64'(c_gnt), 64'h1);
        rst_n = 1'b0; c_req = 1'b0; c_we = 1'b0;
        model_reset();
        #1;
        check("rw_busy", 64'(busy), 64'h0);
        step(); step();
        rst_n = 1'b1;
        step();
        check("rw_slot5", 64'(cfg_flat[47:40]), 64'h00);
        check("rw_rvalid", 64'(c_rvalid), 64'h0);
        c_req = 1'b1; c_we = 1'b0; c_addr = 3'd5;
        step();
        check("rw_idle_gnt", 64'(c_gnt), 64'h1);
        step();
        check("rw_rdata", 64'({c_rvalid, c_rdata}), 64'h100);
        c_req = 1'b0;
        step();

        // Random traffic
        g_prev = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (c_req && g_prev) c_req = 1'b0;
            if (!c_req && $urandom_range(0, 2) == 0) begin
                c_req   = 1'b1;
                c_we    = 1'($urandom_range(0, 1));
                c_addr  = 3'($urandom_range(0, 7));
                c_wdata = 8'($urandom_range(0, 255));
            end
            if (h_cnt == 0) begin
                if (h_wr) begin
                    h_wr  = 1'b0;
                    h_cnt = $urandom_range(0, 5);
                end else begin
                    h_wr    = 1'b1;
                    h_addr  = 8'($urandom_range(0, 10));
                    h_wdata = 8'($urandom_range(0, 255));
                    h_cnt   = $urandom_range(0, 5);
                end
            end else begin
                h_cnt--;
            end
            g_prev = exp_gnt();
            step();
        end
        c_req = 1'b0; h_wr = 1'b0;
        repeat (4) step();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ppt_reg_arbiter.md
Name: ppt_reg_arbiter

Overview:
- Configuration register bank shared by two requesters: the I2C slave register port (SCL domain, asynchronous to clk) and the local presentation-controller core (clk domain).
- Synchronizes the I2C write strobe and buffers one pending host write.
- Round-robin arbitrates the bank's single access port between host and core.
- Exposes all registers flattened as configuration for the core datapath.

Parameters:
- ADDR_W, 3, register address width; bank depth = 2**ADDR_W.
- DATA_W, 8, register width.
- SYNC_STAGES, 2, flops in the h_wr synchronizer (minimum 2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- h_wr  in  1  host write strobe, SCL domain; level held high ≥ SYNC_STAGES+2 clk
- h_addr  in  8  host register address; stable while h_wr high
- h_wdata  in  DATA_W  host write data; stable while h_wr high
- h_rdata  out  DATA_W  bank[h_addr], registered shadow read
- c_req  in  1  core access request; held until c_gnt
- c_we  in  1  core write (1) / read (0); stable with c_req
- c_addr  in  ADDR_W  core address
- c_wdata  in  DATA_W  core write data
- c_gnt  out  1  one-cycle grant pulse
- c_rvalid  out  1  one-cycle core read-data valid
- c_rdata  out  DATA_W  core read data
- cfg_flat  out  DATA_W*2**ADDR_W  all registers; reg i at [i*DATA_W +: DATA_W]
- busy  out  1  FSM in ACCESS or host write pending
- host_ovr  out  1  sticky: host write overwritten before service
- host_drop  out  1  sticky: host write to address ≥ 2**ADDR_W discarded

Behaviour:
- Reset (async, rst_n=0):
  - all bank registers = 0; h_rdata=0; c_gnt=0; c_rvalid=0; c_rdata=0.
  - busy=0; host_ovr=0; host_drop=0; sync chain=0; pending=0; FSM=IDLE; last_grant=CORE (host wins first tie).
  - Reset mid-ACCESS aborts the access; no write is committed.
- Host synchronizer:
  - h_wr passes through SYNC_STAGES flops, then one edge-detect flop.
  - A rising edge in cycle E captures h_addr and h_wdata into the pending buffer at the end of E. pending=1 from E+1.
  - If h_addr ≥ 2**ADDR_W: do not set pending; set host_drop at E+1.
  - If pending is already 1 and not being serviced in E: overwrite the buffer and set host_ovr.
- FSM, two states:
  - IDLE: if pending or c_req, choose a winner and go to ACCESS next cycle; otherwise stay.
    - Both requesting: winner = side opposite last_grant.
    - One requesting: that side wins.
    - last_grant is updated to the winner.
  - ACCESS: lasts one cycle, then always returns to IDLE.
    - Maximum throughput: one access per 2 cycles.
- ACCESS for host: bank[pend_addr] <= pend_wdata at the end of the cycle; pending cleared.
  - If a new host edge is captured in the same cycle, the new capture wins: pending stays 1 with the new data, and host_ovr is not set.
- ACCESS for core:
  - c_gnt=1 during ACCESS.
  - Write: bank[c_addr] <= c_wdata at the end of the cycle.
  - Read: c_rdata <= bank[c_addr]; c_rvalid=1 in the following cycle. c_rdata holds until the next core read.
  - Request-to-grant latency: 1 cycle minimum, 3 cycles worst case under host contention.
- h_rdata:
  - Updated every cycle from bank[h_addr[ADDR_W-1:0]], independent of arbitration.
  - Reflects a committed write one cycle after it commits.
  - Returns 0 for out-of-range h_addr.
- cfg_flat: direct wiring of the bank registers; updates in the cycle after a write commits.
- busy = (state==ACCESS) | pending.
- Core deasserting c_req before grant is illegal; behaviour is undefined and flagged by a bench assertion.
- host_ovr and host_drop clear only on reset.

Test Plan:
- Reset, then host write h_addr=0x02, h_wdata=0xA5, h_wr high 6 clk → pending at SYNC_STAGES+2, commit one cycle later; cfg_flat[23:16]=0xA5; h_rdata=0xA5 with h_addr=0x02; host_ovr=0.
- Core read c_addr=2 after the above → c_gnt at the cycle after c_req; c_rvalid one cycle later with c_rdata=0xA5.
- Host pending and core c_req rise in the same cycle, repeated 4 times → grants alternate H,C,H,C; each core grant within 3 cycles.
- Host write addr=0x09 data=0x33 → host_drop=1; bank unchanged; busy stays 0.
- Core holds c_req continuously while two host edges arrive 1 cycle apart after sync → second overwrites first; host_ovr=1; only the second value is committed.
- rst_n low during a core-write ACCESS to addr=5 with data 0x7E → bank[5]=0, c_rvalid=0, FSM in IDLE after release.
